// File: rtl/avmm_timeout_stage.sv
// avmm_timeout_stage: registered Avalon-MM stage that breaks the waitrequest/readdata path
// and abandons a slave that stalls too long. Define AVMM_TIMEOUT_STATUS_EN to add timeout status ports.
module avmm_timeout_stage #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] s0_addr,
    input  logic                     s0_read,
    input  logic                     s0_write,
    input  logic [DATA_WIDTH-1:0]    s0_writedata,
    output logic [DATA_WIDTH-1:0]    s0_readdata,
    output logic                     s0_waitrequest,
`ifdef AVMM_TIMEOUT_STATUS_EN
    input  logic                     timeout_clr,
    output logic                     timeout_flag,
    output logic [ADDRESS_WIDTH-1:0] timeout_addr,
    output logic [15:0]              timeout_count,
`endif
    output logic [ADDRESS_WIDTH-1:0] m0_addr,
    output logic                     m0_read,
    output logic                     m0_write,
    output logic [DATA_WIDTH-1:0]    m0_writedata,
    input  logic [DATA_WIDTH-1:0]    m0_readdata,
    input  logic                     m0_waitrequest
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? {CNT_W{1'b0}}
                                                                  : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] TO_DATA = DATA_WIDTH'(TIMEOUT_DATA);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [CNT_W-1:0]         r_cnt;
    logic [ADDRESS_WIDTH-1:0] r_m0_addr;
    logic [DATA_WIDTH-1:0]    r_m0_writedata;
    logic                     r_m0_read;
    logic                     r_m0_write;
    logic [DATA_WIDTH-1:0]    r_s0_readdata;
    logic                     r_s0_waitrequest;

    logic w_req;
    logic w_grant;
    logic w_timeout;

    assign w_req     = s0_read | s0_write;
    assign w_grant   = (r_state == S_ISSUE) && !m0_waitrequest;
    // A grant on the expiring cycle takes priority, so timeout requires waitrequest still high.
    assign w_timeout = TO_EN && (r_state == S_ISSUE) && m0_waitrequest && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next = S_ISSUE;
            S_ISSUE: if (w_grant || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt            <= '0;
            r_m0_addr        <= '0;
            r_m0_writedata   <= '0;
            r_m0_read        <= 1'b0;
            r_m0_write       <= 1'b0;
            r_s0_readdata    <= '0;
            r_s0_waitrequest <= 1'b1;
        end else begin
            r_s0_waitrequest <= (w_next != S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_m0_addr      <= s0_addr;
                        r_m0_writedata <= s0_writedata;
                        r_m0_write     <= s0_write;
                        // Simultaneous read and write is illegal upstream; only the write goes out.
                        r_m0_read      <= s0_read & ~s0_write;
                        r_cnt          <= '0;
                    end
                end
                S_ISSUE: begin
                    if (w_grant) begin
                        r_m0_read  <= 1'b0;
                        r_m0_write <= 1'b0;
                        if (r_m0_read) r_s0_readdata <= m0_readdata;
                    end else if (w_timeout) begin
                        r_m0_read  <= 1'b0;
                        r_m0_write <= 1'b0;
                        if (r_m0_read) r_s0_readdata <= TO_DATA;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s0_readdata    = r_s0_readdata;
    assign s0_waitrequest = r_s0_waitrequest;
    assign m0_addr        = r_m0_addr;
    assign m0_read        = r_m0_read;
    assign m0_write       = r_m0_write;
    assign m0_writedata   = r_m0_writedata;

`ifdef AVMM_TIMEOUT_STATUS_EN
    logic                     r_to_flag;
    logic [ADDRESS_WIDTH-1:0] r_to_addr;
    logic [15:0]              r_to_count;

    // A timeout on the same cycle as a clear restarts the status from this event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_flag  <= 1'b0;
            r_to_addr  <= '0;
            r_to_count <= '0;
        end else if (w_timeout) begin
            r_to_flag <= 1'b1;
            if (!r_to_flag || timeout_clr) r_to_addr <= r_m0_addr;
            if (timeout_clr) begin
                r_to_count <= 16'd1;
            end else if (r_to_count != 16'hFFFF) begin
                r_to_count <= r_to_count + 16'd1;
            end
        end else if (timeout_clr) begin
            r_to_flag  <= 1'b0;
            r_to_addr  <= '0;
            r_to_count <= '0;
        end
    end

    assign timeout_flag  = r_to_flag;
    assign timeout_addr  = r_to_addr;
    assign timeout_count = r_to_count;
`endif

endmodule
